// File: rtl/can_tx_pkg.sv
// rtl/can_tx_pkg.sv - shared types and constants for the CAN transmit bit-stream unit
package can_tx_pkg;

  // Transmit FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STUFF = 2'd2
  } tx_state_t;

  // Bus levels
  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  // Run length of equal bits that forces a complementary stuff bit
  localparam int DEF_STUFF_LIMIT = 5;

  // Width of the run counter; limits STUFF_LIMIT to at most 7
  localparam int CNT_W = 3;

endpackage

// File: rtl/can_tx_runcnt.sv
// rtl/can_tx_runcnt.sv - equal-bit run counter and last-bit register for stuffing
module can_tx_runcnt
  import can_tx_pkg::*;
#(
  parameter int STUFF_LIMIT = DEF_STUFF_LIMIT
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic             i_bit,
  output logic [CNT_W-1:0] o_count,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STUFF_LIMIT);

  logic [CNT_W-1:0] r_count;
  logic             r_last;

  // Clear returns to the idle values, load starts a new run at one,
  // inc extends the current run and saturates at the stuff limit.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_count <= '0;
      r_last  <= RECESSIVE;
    end else if (i_clear) begin
      r_count <= '0;
      r_last  <= RECESSIVE;
    end else if (i_load) begin
      r_count <= CNT_W'(1);
      r_last  <= i_bit;
    end else if (i_inc) begin
      if (r_count < LIMIT) begin
        r_count <= r_count + CNT_W'(1);
      end
      r_last <= i_bit;
    end
  end

  assign o_count = r_count;
  assign o_last  = r_last;

endmodule

// File: rtl/can_tx_bitstuffer.sv
// rtl/can_tx_bitstuffer.sv - CAN transmit bit driver with stuffing and bus monitoring
module can_tx_bitstuffer
  import can_tx_pkg::*;
#(
  parameter int STUFF_LIMIT = DEF_STUFF_LIMIT
) (
  input  logic clock,
  input  logic reset,
  input  logic Prescale_EN,
  input  logic tx_start,
  input  logic tx_stop,
  input  logic tx_data,
  input  logic stuff_en,
  input  logic arb,
  input  logic smpldbit,
  output logic tx,
  output logic data_req,
  output logic stuff_bit,
  output logic bit_err,
  output logic arb_lost
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STUFF_LIMIT);

  tx_state_t r_state;
  logic      r_tx;
  logic      r_stuff_bit;
  logic      r_data_req;
  logic      r_bit_err;
  logic      r_arb_lost;
  logic      r_start_pend;

  tx_state_t w_state_nxt;
  logic      w_tx_nxt;
  logic      w_stuff_nxt;
  logic      w_dreq_nxt;
  logic      w_berr_nxt;
  logic      w_alost_nxt;
  logic      w_pend_nxt;

  logic             w_cnt_clear;
  logic             w_cnt_load;
  logic             w_cnt_inc;
  logic             w_cnt_bit;
  logic [CNT_W-1:0] w_count;
  logic             w_last;

  logic w_mismatch;
  logic w_arb_loss;
  logic w_at_limit;

  can_tx_runcnt #(
    .STUFF_LIMIT(STUFF_LIMIT)
  ) u_runcnt (
    .i_clk    (clock),
    .i_resetn (reset),
    .i_clear  (w_cnt_clear),
    .i_load   (w_cnt_load),
    .i_inc    (w_cnt_inc),
    .i_bit    (w_cnt_bit),
    .o_count  (w_count),
    .o_last   (w_last)
  );

  // The bit on tx has completed when the next bit is due, so smpldbit is
  // compared against the value still being driven.
  assign w_mismatch = (smpldbit != r_tx);
  assign w_arb_loss = arb && (r_tx == RECESSIVE) && (smpldbit == DOMINANT);
  assign w_at_limit = (w_count == LIMIT);

  // Next-state and next-output decode; bit-level actions only on Prescale_EN
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_stuff_nxt = r_stuff_bit;
    w_dreq_nxt  = 1'b0;
    w_berr_nxt  = 1'b0;
    w_alost_nxt = 1'b0;
    w_pend_nxt  = r_start_pend;
    w_cnt_clear = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cnt_bit   = tx_data;

    case (r_state)
      IDLE: begin
        w_tx_nxt    = RECESSIVE;
        w_stuff_nxt = 1'b0;
        if (Prescale_EN && (tx_start || r_start_pend)) begin
          w_tx_nxt    = tx_data;
          w_dreq_nxt  = 1'b1;
          w_cnt_load  = 1'b1;
          w_pend_nxt  = 1'b0;
          w_state_nxt = SEND;
        end else if (tx_start && !Prescale_EN) begin
          // A start request between bit times waits for the next one
          w_pend_nxt = 1'b1;
        end
      end

      SEND, STUFF: begin
        if (Prescale_EN) begin
          if (w_arb_loss) begin
            // Another node won arbitration: release the bus immediately
            w_alost_nxt = 1'b1;
            w_tx_nxt    = RECESSIVE;
            w_stuff_nxt = 1'b0;
            w_cnt_clear = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            // Bit errors are only reported; the MAC decides whether to abort
            w_berr_nxt = w_mismatch;
            if (tx_stop) begin
              w_tx_nxt    = RECESSIVE;
              w_stuff_nxt = 1'b0;
              w_cnt_clear = 1'b1;
              w_state_nxt = IDLE;
            end else if (stuff_en && w_at_limit) begin
              // Stuff bit starts the next run; tx_data stays unconsumed
              w_tx_nxt    = ~w_last;
              w_stuff_nxt = 1'b1;
              w_cnt_load  = 1'b1;
              w_cnt_bit   = ~w_last;
              w_state_nxt = STUFF;
            end else begin
              w_tx_nxt    = tx_data;
              w_dreq_nxt  = 1'b1;
              w_stuff_nxt = 1'b0;
              w_state_nxt = SEND;
              // Outside the stuffed region each bit restarts the run at one
              if (stuff_en && (tx_data == w_last)) begin
                w_cnt_inc = 1'b1;
              end else begin
                w_cnt_load = 1'b1;
              end
            end
          end
        end
      end

      default: begin
        w_tx_nxt    = RECESSIVE;
        w_stuff_nxt = 1'b0;
        w_cnt_clear = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset releases the bus at the next edge
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_tx         <= RECESSIVE;
      r_stuff_bit  <= 1'b0;
      r_data_req   <= 1'b0;
      r_bit_err    <= 1'b0;
      r_arb_lost   <= 1'b0;
      r_start_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tx         <= w_tx_nxt;
      r_stuff_bit  <= w_stuff_nxt;
      r_data_req   <= w_dreq_nxt;
      r_bit_err    <= w_berr_nxt;
      r_arb_lost   <= w_alost_nxt;
      r_start_pend <= w_pend_nxt;
    end
  end

  assign tx        = r_tx;
  assign data_req  = r_data_req;
  assign stuff_bit = r_stuff_bit;
  assign bit_err   = r_bit_err;
  assign arb_lost  = r_arb_lost;

endmodule

// File: doc/can_tx_bitstuffer.md
# can_tx_bitstuffer

Transmit-side bit-stream unit of the CAN controller. It sits between the transmit MAC and the bus driver. The MAC supplies one frame bit per bit time. This block drives the `tx` line, inserts a complementary stuff bit after five equal bits, and monitors the bus. For monitoring it compares each completed transmitted bit with the sampled bus bit delivered by the receive sample buffer. It flags bit errors and arbitration loss to the MAC.

## Interface
- Parameters:
  - `STUFF_LIMIT`, default 5: run length of equal bits that triggers a stuff bit.
- Ports:
  - `clock` in 1: system clock.
  - `reset` in 1: active-low, synchronous.
  - `Prescale_EN` in 1: one-clock pulse per bit time, at the transmit point. All bit-level actions happen only in cycles where it is 1.
  - `tx_start` in 1: pulse from the MAC requesting frame start. Its first bit (SOF) is on `tx_data`.
  - `tx_stop` in 1: level or pulse; end transmission and release the bus.
  - `tx_data` in 1: next frame bit from the MAC. Valid whenever a bit is due.
  - `stuff_en` in 1: 1 from SOF through the CRC sequence, 0 afterwards.
  - `arb` in 1: 1 while in the arbitration field.
  - `smpldbit` in 1: sampled bus value of the bit currently being driven.
  - `tx` out 1: bus drive; 1 is recessive.
  - `data_req` out 1: one-cycle pulse; `tx_data` was consumed this cycle.
  - `stuff_bit` out 1: 1 while the bit on `tx` is a stuff bit.
  - `bit_err` out 1: one-cycle pulse on a monitoring mismatch.
  - `arb_lost` out 1: one-cycle pulse on lost arbitration.

## Operation
- Reset values (`reset`=0 at a rising edge):
  - `tx`=1.
  - `data_req`, `stuff_bit`, `bit_err`, `arb_lost` = 0.
  - Internal state: state IDLE, start_pend=0, run count=0, last bit=1.
- Three states: IDLE, SEND, STUFF.
- IDLE:
  - `tx`=1.
  - `tx_start` with `Prescale_EN`=0 sets start_pend.
  - At `Prescale_EN` with `tx_start` or start_pend: `tx`<=`tx_data`, pulse `data_req`, count=1, last=`tx_data`, clear start_pend, go to SEND.
  - No monitoring in IDLE.
- SEND/STUFF, at each `Prescale_EN`, evaluated in this order:
  1. **Monitor.** `smpldbit` is compared with the bit just completed.
     - If `arb`=1, `tx`=1 and `smpldbit`=0: pulse `arb_lost`, `tx`<=1, go to IDLE, no `data_req`.
     - Any other mismatch: pulse `bit_err`, then continue normally. The MAC decides the abort.
  2. **Stop.** If `tx_stop`=1: `tx`<=1, `stuff_bit`<=0, go to IDLE, no `data_req`.
  3. **Stuff.** If `stuff_en`=1 and count=`STUFF_LIMIT`: `tx`<=~last, `stuff_bit`<=1, last<=~last, count<=1, go to STUFF. `tx_data` is not consumed and `data_req` stays 0.
  4. **Data.** Otherwise: `tx`<=`tx_data`, pulse `data_req`, `stuff_bit`<=0, go to SEND.
     - Count becomes count+1 if `tx_data`=last, else 1.
     - last<=`tx_data`.
     - If `stuff_en`=0, count is held at 1.
- Count rules:
  - 3-bit counter, never exceeds `STUFF_LIMIT`.
  - A stuff bit counts as the first bit of the next run.
- If `stuff_en` falls while count=5, no stuff bit is inserted (CRC delimiter case).
- Between `Prescale_EN` pulses, all outputs hold, except the one-cycle pulses, which return to 0.

## Timing
- `tx` changes only on the clock edge of a `Prescale_EN` cycle. Latency from `tx_data` to `tx` is one clock.
- `data_req`, `bit_err` and `arb_lost` are asserted in the cycle after the `Prescale_EN` edge, for exactly one clock.
- `bit_err` and `data_req` can assert in the same cycle.
- `arb_lost` excludes `data_req` in the same cycle.
- `tx_start` during SEND/STUFF is ignored.
- `tx_stop` takes priority over a pending stuff bit.
- `reset` overrides everything, including a transmission in progress: `tx` returns to 1 at the next edge.

## Structure
- Shared package `can_tx_pkg`:
  - state enum (IDLE, SEND, STUFF);
  - `RECESSIVE`=1'b1, `DOMINANT`=1'b0;
  - default `STUFF_LIMIT`.
- One sub-module, `can_tx_runcnt`: run counter plus last-bit register, with inputs load/inc/clear. The top level holds the FSM and the monitor.

## Test plan
- **Start.** Reset, then `tx_start` one clock before `Prescale_EN`, `tx_data`=0. Expect start_pend captured; `tx`=0 after the next `Prescale_EN`; one `data_req`.
- **Stuffing.** `stuff_en`=1, data 0,0,0,0,0,0. Expect `tx` sequence 0,0,0,0,0,1(stuff),0; `stuff_bit`=1 only on bit 6; 6 `data_req` pulses over 7 bit times.
- **Stuff disabled.** `stuff_en` falls after the 5th equal bit 1. Expect no stuff bit; `tx`=1 for the 6th bit.
- **Arbitration loss.** `arb`=1, `tx`=1, `smpldbit`=0. Expect `arb_lost` pulse, `tx`=1, state IDLE, no `data_req`.
- **Bit error.** `arb`=0, `tx`=0, `smpldbit`=1. Expect `bit_err` pulse; the next bit is still sent with `data_req`.
- **Mid-frame reset.** `reset`=0 during STUFF. Expect `tx`=1, `stuff_bit`=0 at the next edge; count cleared.
